pipe_field: RTL
===============

Name: pipe_field

Overview:
- Parametrised pipe-course engine for the Flappy Bird game. It replaces the fixed two-pipe pair with NUM_PIPES scrolling pipes.
- Per pipe: position, random gap height, respawn on scroll-off.
- Also handles score counting, bird/pipe/floor collision detection and the game-state FSM (IDLE/RUN/LOST) with restart.
- Sits between the bird module and vga_bitchange. Consumes bird position; drives flattened pipe buses, Score (to SSD driver) and Lost.

Parameters:
- NUM_PIPES, 3: number of pipes, 1..6.
- SCREEN_W, 640: playfield width in pixels; initial spawn X of pipe 0.
- SCREEN_H, 480: playfield height; the floor is at row SCREEN_H.
- PIPE_W, 40: pipe column width in pixels.
- GAP_H, 120: vertical opening height.
- GAP_MIN, 60: minimum gap top. Gap top = GAP_MIN + 8-bit random value. Constraint: GAP_MIN+255+GAP_H <= SCREEN_H.
- SPACING, 240: horizontal distance between pipe left edges. Constraint: NUM_PIPES*SPACING >= SCREEN_W+PIPE_W, and SCREEN_W+(NUM_PIPES-1)*SPACING < 2048.
- SPEED, 1: pixels moved per scroll tick. Constraint: 1 <= SPEED < PIPE_W.
- TICK_DIV, 500000: Clk cycles per scroll tick (200 Hz at 100 MHz).
- BIRD_W, 20: bird box width.
- BIRD_H, 20: bird box height.

Ports:
- Clk  in  1  system clock (100 MHz).
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  start/restart button, level; rising edge detected internally.
- BirdX  in  10  bird left edge; must be > SPEED.
- BirdY  in  10  bird top edge.
- PipeX  out  11*NUM_PIPES  pipe left edges; pipe i in bits [11i+10:11i].
- PipeY  out  10*NUM_PIPES  gap top rows; pipe i in bits [10i+9:10i].
- Score  out  16  pipes passed, binary, saturating.
- Lost  out  1  high in LOST state.
- Running  out  1  high in RUN state.
- Tick  out  1  one-cycle scroll strobe (RUN only).

Behaviour:
- One clock, Clk. Reset is synchronous and active-high; it overrides everything in the cycle sampled, including mid-RUN.
- Reset values:
  - state = IDLE.
  - PipeX[i] = SCREEN_W + i*SPACING.
  - PipeY[i] = GAP_MIN+128.
  - Score = 0; Lost = 0; Running = 0; Tick = 0.
  - Tick counter = 0; LFSR = 16'hACE1; Start edge register = 0.
- Start edge: start_rise = Start & ~Start_q. Start_q is registered every cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in all states and is never zero.
- IDLE:
  - Outputs held; tick counter held at 0.
  - start_rise -> RUN. Running = 1 the next cycle.
- RUN, tick generation:
  - Counter counts 0..TICK_DIV-1. At terminal count it wraps to 0 and Tick = 1 for exactly one cycle.
  - This gives the first Tick TICK_DIV cycles after entering RUN.
- RUN, on each Tick, for each pipe i:
  - If PipeX[i] < SPEED: respawn. PipeX[i] <= PipeX[i] + NUM_PIPES*SPACING - SPEED, which preserves spacing. PipeY[i] <= GAP_MIN + rnd.
  - rnd is lfsr[7:0] for the lowest-index respawning pipe that tick and lfsr[15:8] for any other.
  - Otherwise PipeX[i] <= PipeX[i] - SPEED.
- Score:
  - On a Tick where (PipeX[i]+PIPE_W >= BirdX) before the move and < BirdX after it, Score += 1, computed at 11-bit width.
  - Multiple pipes crossing on the same Tick add their count.
  - Score saturates at 16'hFFFF.
- Collision, combinational, evaluated every RUN cycle:
  - Floor hit: BirdY+BIRD_H > SCREEN_H.
  - Pipe hit, for any pipe i: horizontal overlap (BirdX < PipeX[i]+PIPE_W and BirdX+BIRD_W > PipeX[i]) AND vertical miss (BirdY < PipeY[i] or BirdY+BIRD_H > PipeY[i]+GAP_H).
  - All arithmetic is 12-bit unsigned.
- Collision in RUN -> LOST next cycle; Lost = 1, Running = 0.
  - Collision in the same cycle as Tick: LOST wins. Pipes do not move and Score does not change on that Tick.
- LOST:
  - All pipe outputs and Score frozen; Tick = 0.
  - start_rise -> re-initialise pipes, Score and tick counter to reset values (LFSR not reseeded) and go to IDLE.
  - A further start_rise is required to enter RUN.
- Holding Start high never retriggers; only rising edges count.

Test Plan:
Bench parameters unless stated: NUM_PIPES=3, TICK_DIV=4, defaults otherwise.
1. Reset 2 cycles -> PipeX = {1120,880,640}, PipeY = 188 for all pipes, Score=0, Lost=0, Running=0, Tick=0.
2. 1-cycle Start pulse -> Running=1 the next cycle; Tick pulses every 4 cycles; PipeX[0] = 638 after the 2nd Tick. Holding Start high 20 cycles causes no extra transition.
3. Force PipeX[0] to reach 0, then Tick -> PipeX[0] = 719 and PipeY[0] = 60 + lfsr[7:0], checked against the reference-model LFSR. Other pipes decrement by 1.
4. BirdX=100, BirdY=250, gap at 188..308 -> Score goes 0->1 on the Tick taking PipeX[0] from 60 to 59. No Lost.
5. BirdY=0, BirdX=100 -> Lost=1 one cycle after PipeX[0] reaches 119. Pipes frozen for 40 following cycles. Separately, BirdY=470 with no pipe nearby -> Lost via floor.
6. In LOST, Start rising edge -> reset values, IDLE (Running=0, Lost=0); 2nd Start rising edge -> RUN. Separately, Reset asserted mid-RUN with Score=3 -> all reset values the next cycle.

Source files
------------

// File: rtl/pipe_field.sv
// pipe_field: NUM_PIPES scrolling pipes with random gaps, score counting,
// bird/pipe/floor collision detection and the IDLE/RUN/LOST game FSM.
module pipe_field #(
  parameter int NUM_PIPES = 3,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 60,
  parameter int SPACING   = 240,
  parameter int SPEED     = 1,
  parameter int TICK_DIV  = 500000,
  parameter int BIRD_W    = 20,
  parameter int BIRD_H    = 20
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [9:0]              BirdX,
  input  logic [9:0]              BirdY,
  output logic [11*NUM_PIPES-1:0] PipeX,
  output logic [10*NUM_PIPES-1:0] PipeY,
  output logic [15:0]             Score,
  output logic                    Lost,
  output logic                    Running,
  output logic                    Tick
);

  localparam int               CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [10:0]      SPEED_X     = 11'(SPEED);
  localparam logic [11:0]      RESPAWN_ADD = 12'(NUM_PIPES * SPACING - SPEED);
  localparam logic [11:0]      PIPE_W_E    = 12'(PIPE_W);
  localparam logic [11:0]      GAP_H_E     = 12'(GAP_H);
  localparam logic [11:0]      BIRD_W_E    = 12'(BIRD_W);
  localparam logic [11:0]      BIRD_H_E    = 12'(BIRD_H);
  localparam logic [11:0]      SCREEN_H_E  = 12'(SCREEN_H);
  localparam logic [9:0]       GAP_MIN_Y   = 10'(GAP_MIN);
  localparam logic [9:0]       INIT_Y      = 10'(GAP_MIN + 128);
  localparam logic [15:0]      LFSR_SEED   = 16'hACE1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOST = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             start_q, start_rise;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic             tick_nxt, hit, rnd_taken;
  logic [10:0]      pipe_x     [NUM_PIPES];
  logic [10:0]      pipe_x_nxt [NUM_PIPES];
  logic [10:0]      moved_x    [NUM_PIPES];
  logic [9:0]       pipe_y     [NUM_PIPES];
  logic [9:0]       pipe_y_nxt [NUM_PIPES];
  logic [9:0]       moved_y    [NUM_PIPES];
  logic [15:0]      score, score_nxt, score_sat;
  logic [10:0]      passed;
  logic [16:0]      score_sum;
  logic [11:0]      bird_x, bird_y;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [10:0] init_x(input int idx);
    return 11'(SCREEN_W + idx * SPACING);
  endfunction

  assign start_rise = Start & ~start_q;
  assign bird_x     = {2'b00, BirdX};
  assign bird_y     = {2'b00, BirdY};

  // Bird box against the floor and every pipe column outside its gap
  always_comb begin
    hit = (bird_y + BIRD_H_E) > SCREEN_H_E;
    for (int i = 0; i < NUM_PIPES; i++) begin
      hit = hit | ((bird_x < ({1'b0, pipe_x[i]} + PIPE_W_E)) &
                   ((bird_x + BIRD_W_E) > {1'b0, pipe_x[i]}) &
                   ((bird_y < {2'b00, pipe_y[i]}) |
                    ((bird_y + BIRD_H_E) > ({2'b00, pipe_y[i]} + GAP_H_E))));
    end
  end

  // Candidate positions and score for a scroll tick; the first respawn takes the low LFSR byte
  always_comb begin
    rnd_taken = 1'b0;
    passed    = 11'd0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pipe_x[i] < SPEED_X) begin
        moved_x[i] = 11'({1'b0, pipe_x[i]} + RESPAWN_ADD);
        moved_y[i] = GAP_MIN_Y + (rnd_taken ? {2'b00, lfsr[15:8]} : {2'b00, lfsr[7:0]});
        rnd_taken  = 1'b1;
      end else begin
        moved_x[i] = pipe_x[i] - SPEED_X;
        moved_y[i] = pipe_y[i];
      end
      if ((({1'b0, pipe_x[i]} + PIPE_W_E) >= bird_x) &&
          (({1'b0, moved_x[i]} + PIPE_W_E) < bird_x)) begin
        passed = passed + 11'd1;
      end else begin
        passed = passed;
      end
    end
    score_sum = {1'b0, score} + {6'd0, passed};
    score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Game FSM next state; collision pre-empts a coincident tick
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    tick_nxt     = 1'b0;
    score_nxt    = score;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x_nxt[i] = pipe_x[i];
      pipe_y_nxt[i] = pipe_y[i];
    end
    case (state)
      IDLE: begin
        tick_cnt_nxt = CNT_ZERO;
        if (start_rise) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (hit) begin
          state_nxt = LOST;
        end else if (tick_cnt == CNT_LAST) begin
          tick_cnt_nxt = CNT_ZERO;
          tick_nxt     = 1'b1;
          score_nxt    = score_sat;
          for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x_nxt[i] = moved_x[i];
            pipe_y_nxt[i] = moved_y[i];
          end
        end else begin
          tick_cnt_nxt = tick_cnt + CNT_ONE;
        end
      end
      LOST: begin
        if (start_rise) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = CNT_ZERO;
          score_nxt    = 16'd0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x_nxt[i] = init_x(i);
            pipe_y_nxt[i] = INIT_Y;
          end
        end else begin
          state_nxt = LOST;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      lfsr     <= LFSR_SEED;
      tick_cnt <= CNT_ZERO;
      score    <= 16'd0;
      Tick     <= 1'b0;
      Lost     <= 1'b0;
      Running  <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x[i] <= init_x(i);
        pipe_y[i] <= INIT_Y;
      end
    end else begin
      state    <= state_nxt;
      start_q  <= Start;
      lfsr     <= lfsr_step(lfsr);
      tick_cnt <= tick_cnt_nxt;
      score    <= score_nxt;
      Tick     <= tick_nxt;
      Lost     <= (state_nxt == LOST);
      Running  <= (state_nxt == RUN);
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x[i] <= pipe_x_nxt[i];
        pipe_y[i] <= pipe_y_nxt[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PIPES; g++) begin : g_bus
      assign PipeX[11*g +: 11] = pipe_x[g];
      assign PipeY[10*g +: 10] = pipe_y[g];
    end
  endgenerate

  assign Score = score;

endmodule
